// File: rtl/ecall_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : ecall_io_responder
// Brief    : Services core ecall I/O requests (print, read-int, exit).
// Revision : 1.0 - initial release
// ============================================================================
module ecall_io_responder #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ecall,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_btn,
  output logic                stall,
  output logic [31:0]         io_input,
  output logic                rd_valid,
  output logic [31:0]         display_data,
  output logic                display_valid,
  output logic                halted,
  output logic [7:0]          led_out
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_RESP         = 3'd3,
    S_HALT         = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_io_input;
  logic [31:0]      r_display_data;
  logic             r_display_valid;

  logic w_rise;
  logic w_fall;
  logic w_code_print;
  logic w_code_read;
  logic w_code_exit;
  logic w_awaiting;

  assign w_rise       = r_deb & ~r_deb_prev;
  assign w_fall       = ~r_deb & r_deb_prev;
  assign w_code_print = (a7 == 32'd1);
  assign w_code_read  = (a7 == 32'd5);
  assign w_code_exit  = (a7 == 32'd10);
  assign w_awaiting   = (r_state == S_WAIT_PRESS) || (r_state == S_WAIT_RELEASE);

  // Button: 2-flop synchronizer, then level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= confirm_btn;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      if (r_sync2 != r_deb) begin
        if (r_cnt == C_CNT_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_io_input      <= '0;
      r_display_data  <= '0;
      r_display_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ecall) begin
            if (w_code_print) begin
              r_display_data  <= a0;
              r_display_valid <= 1'b1;
            end else if (w_code_read) begin
              r_state <= S_WAIT_PRESS;
            end else if (w_code_exit) begin
              r_state <= S_HALT;
            end
          end
        end
        S_WAIT_PRESS: begin
          if (w_rise) begin
            r_io_input <= 32'(switches);
            r_state    <= S_WAIT_RELEASE;
          end
        end
        S_WAIT_RELEASE: begin
          if (w_fall) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall asserts in the request cycle itself so the core never advances past a read/exit.
  assign stall = ((r_state == S_IDLE) && ecall && (w_code_read || w_code_exit)) ||
                 w_awaiting || (r_state == S_HALT);

  assign io_input      = r_io_input;
  assign rd_valid      = (r_state == S_RESP);
  assign display_data  = r_display_data;
  assign display_valid = r_display_valid;
  assign halted        = (r_state == S_HALT);
  assign led_out       = {w_awaiting, 5'b00000, r_display_valid, halted};

endmodule
`default_nettype wire
